// File: rtl/cci_mpf_shim_expand_wr_rsp_if.sv
// Write-response bus between the c1Rx source and the expansion shim: packed
// responses in, one single-line flit per cycle out.
interface cci_mpf_shim_expand_wr_rsp_if #(
  parameter int MDATA_WIDTH = 16
);
  logic                   rsp_en;
  logic [MDATA_WIDTH-1:0] rsp_mdata;
  logic                   rsp_format;
  logic [1:0]             rsp_clNum;

  logic                   out_en;
  logic [MDATA_WIDTH-1:0] out_mdata;
  logic [1:0]             out_clNum;
  logic                   out_eop;

  modport master (
    output rsp_en, rsp_mdata, rsp_format, rsp_clNum,
    input  out_en, out_mdata, out_clNum, out_eop
  );

  modport slave (
    input  rsp_en, rsp_mdata, rsp_format, rsp_clNum,
    output out_en, out_mdata, out_clNum, out_eop
  );
endinterface

// File: rtl/cci_mpf_shim_expand_wr_rsp.sv
// Expands packed CCI write responses into one flit per line. The c1Rx path has
// no backpressure, so responses are buffered and almFull warns the requester.
module cci_mpf_shim_expand_wr_rsp #(
  parameter int N_ENTRIES          = 16,
  parameter int ALM_FULL_THRESHOLD = 4,
  parameter int MDATA_WIDTH        = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  cci_mpf_shim_expand_wr_rsp_if.slave        bus,
  output logic                               almFull,
  output logic                               overflow
);
  localparam int PTR_W = $clog2(N_ENTRIES);
  localparam logic [PTR_W:0] DEPTH     = (PTR_W+1)'(N_ENTRIES);
  localparam logic [PTR_W:0] ALM_LEVEL = (PTR_W+1)'(N_ENTRIES - ALM_FULL_THRESHOLD);
  localparam logic [PTR_W:0] PTR_ONE   = (PTR_W+1)'(1);

  typedef struct packed {
    logic [MDATA_WIDTH-1:0] mdata;
    logic                   format;
    logic [1:0]             clNum;
  } t_entry;

  typedef enum logic {IDLE, EXPAND} t_state;

  t_entry         r_mem [N_ENTRIES];
  logic [PTR_W:0] r_wrPtr;
  logic [PTR_W:0] r_rdPtr;
  t_state         r_state;
  logic [1:0]     r_beat;

  logic [PTR_W:0] w_occ;
  logic [PTR_W:0] w_occNext;
  logic           w_empty;
  logic           w_full;
  logic           w_headValid;
  logic           w_enq;
  logic           w_deq;
  logic [1:0]     w_clNum;
  logic           w_eop;
  t_entry         w_in;
  t_entry         w_head;

  assign w_in        = '{mdata: bus.rsp_mdata, format: bus.rsp_format, clNum: bus.rsp_clNum};
  assign w_occ       = r_wrPtr - r_rdPtr;
  assign w_empty     = (w_occ == '0);
  assign w_full      = (w_occ == DEPTH);
  // An empty FIFO presents the incoming response directly so it issues next cycle.
  assign w_headValid = !w_empty || bus.rsp_en;
  assign w_head      = w_empty ? w_in : r_mem[r_rdPtr[PTR_W-1:0]];

  always_comb begin
    w_clNum = '0;
    w_eop   = 1'b0;
    w_deq   = 1'b0;
    if (w_headValid) begin
      if (r_state == EXPAND) begin
        w_clNum = r_beat;
        w_eop   = (r_beat == w_head.clNum);
        w_deq   = w_eop;
      end else if (!w_head.format) begin
        w_clNum = w_head.clNum;
        w_deq   = 1'b1;
      end else begin
        w_eop   = (w_head.clNum == 2'd0);
        w_deq   = w_eop;
      end
    end
  end

  // A full FIFO still accepts a response when its head retires in the same cycle.
  assign w_enq     = bus.rsp_en && (!w_full || w_deq);
  assign w_occNext = w_occ + {{PTR_W{1'b0}}, w_enq} - {{PTR_W{1'b0}}, w_deq};

  always_ff @(posedge clk) begin
    if (w_enq) r_mem[r_wrPtr[PTR_W-1:0]] <= w_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wrPtr       <= '0;
      r_rdPtr       <= '0;
      r_state       <= IDLE;
      r_beat        <= '0;
      bus.out_en    <= 1'b0;
      bus.out_mdata <= '0;
      bus.out_clNum <= '0;
      bus.out_eop   <= 1'b0;
      almFull       <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      if (w_enq) r_wrPtr <= r_wrPtr + PTR_ONE;
      if (w_deq) r_rdPtr <= r_rdPtr + PTR_ONE;
      if (bus.rsp_en && !w_enq) overflow <= 1'b1;
      almFull       <= (w_occNext >= ALM_LEVEL);
      bus.out_en    <= w_headValid;
      bus.out_mdata <= w_head.mdata;
      bus.out_clNum <= w_clNum;
      bus.out_eop   <= w_eop;
      if (w_headValid) begin
        if (w_deq) begin
          r_state <= IDLE;
          r_beat  <= '0;
        end else if (r_state == IDLE) begin
          r_state <= EXPAND;
          r_beat  <= 2'd1;
        end else begin
          r_beat  <= r_beat + 2'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_cci_mpf_shim_expand_wr_rsp.sv
// Self-checking bench for the write-response expansion shim: a flit scoreboard
// fed at stimulus time plus table vectors and hand-timed corner sequences.
module tb_cci_mpf_shim_expand_wr_rsp;
  localparam int MDW = 16;

  typedef struct packed {
    logic [MDW-1:0] mdata;
    logic [1:0]     clNum;
    logic           eop;
  } t_flit;

  typedef struct {
    logic [MDW-1:0] mdata;
    logic           format;
    logic [1:0]     clNum;
    int             nFlits;
    logic [1:0]     firstCl;
    logic           lastEop;
  } t_vec;

  logic clk = 1'b0;
  logic reset;
  logic almFull;
  logic overflow;

  cci_mpf_shim_expand_wr_rsp_if #(.MDATA_WIDTH(MDW)) bus ();

  cci_mpf_shim_expand_wr_rsp #(
    .N_ENTRIES(16),
    .ALM_FULL_THRESHOLD(4),
    .MDATA_WIDTH(MDW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .almFull(almFull),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  t_flit sbQ[$];
  int    checks       = 0;
  int    errors       = 0;
  bit    allowDrop    = 1'b0;
  int    droppedFlits = 0;
  int    flitCount    = 0;
  int    expFlits     = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Reference expansion: one flit per line of a packed response, one otherwise.
  function automatic void pushExpected(input logic [MDW-1:0] md, input logic fmt,
                                       input logic [1:0] cl);
    if (!fmt) begin
      sbQ.push_back('{mdata: md, clNum: cl, eop: 1'b0});
      expFlits++;
    end else begin
      for (int b = 0; b <= int'(cl); b++) begin
        sbQ.push_back('{mdata: md, clNum: 2'(b), eop: (b == int'(cl))});
        expFlits++;
      end
    end
  endfunction

  task automatic applyStimulus(input logic en, input logic [MDW-1:0] md,
                               input logic fmt, input logic [1:0] cl);
    @(posedge clk);
    #1;
    bus.rsp_en     = en;
    bus.rsp_mdata  = md;
    bus.rsp_format = fmt;
    bus.rsp_clNum  = cl;
    if (en) pushExpected(md, fmt, cl);
  endtask

  task automatic waitDrain(input string name);
    int n = 0;
    while (sbQ.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (sbQ.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s drain: %0d flits still outstanding after 500 cycles", name, sbQ.size());
      sbQ.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  // Scoreboard monitor: every issued flit must match the oldest expected flit.
  always @(negedge clk) begin : monitor
    t_flit exp;
    if (!reset && bus.out_en === 1'b1) begin
      while (allowDrop && sbQ.size() > 0 && sbQ[0].mdata != bus.out_mdata) begin
        void'(sbQ.pop_front());
        droppedFlits++;
      end
      if (sbQ.size() == 0) begin
        checkOutput("spurious out_en", {31'd0, bus.out_en}, 32'd0);
      end else begin
        exp = sbQ.pop_front();
        flitCount++;
        checkOutput("flit mdata", {16'd0, bus.out_mdata}, {16'd0, exp.mdata});
        checkOutput("flit clNum", {30'd0, bus.out_clNum}, {30'd0, exp.clNum});
        checkOutput("flit eop", {31'd0, bus.out_eop}, {31'd0, exp.eop});
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  t_vec       vecs [7];
  logic [1:0] b2bCl [5];
  logic       b2bEop [5];
  int         firstHigh;

  initial begin
    vecs[0] = '{16'h0012, 1'b1, 2'd3, 4, 2'd0, 1'b1};
    vecs[1] = '{16'h0005, 1'b0, 2'd2, 1, 2'd2, 1'b0};
    vecs[2] = '{16'h00a0, 1'b1, 2'd0, 1, 2'd0, 1'b1};
    vecs[3] = '{16'h00a1, 1'b0, 2'd0, 1, 2'd0, 1'b0};
    vecs[4] = '{16'h00a2, 1'b1, 2'd1, 2, 2'd0, 1'b1};
    vecs[5] = '{16'h00a3, 1'b1, 2'd2, 3, 2'd0, 1'b1};
    vecs[6] = '{16'h00a4, 1'b0, 2'd3, 1, 2'd3, 1'b0};
    b2bCl   = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd2};
    b2bEop  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    reset          = 1'b1;
    bus.rsp_en     = 1'b0;
    bus.rsp_mdata  = '0;
    bus.rsp_format = 1'b0;
    bus.rsp_clNum  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset out_en", {31'd0, bus.out_en}, 32'd0);
    checkOutput("reset out_eop", {31'd0, bus.out_eop}, 32'd0);
    checkOutput("reset out_clNum", {30'd0, bus.out_clNum}, 32'd0);
    checkOutput("reset out_mdata", {16'd0, bus.out_mdata}, 32'd0);
    checkOutput("reset almFull", {31'd0, almFull}, 32'd0);
    checkOutput("reset overflow", {31'd0, overflow}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Single responses on an empty FIFO: exact latency and flit count.
    for (int v = 0; v < 7; v++) begin
      applyStimulus(1'b1, vecs[v].mdata, vecs[v].format, vecs[v].clNum);
      for (int k = 0; k <= vecs[v].nFlits; k++) begin
        applyStimulus(1'b0, '0, 1'b0, '0);
        @(negedge clk);
        if (k < vecs[v].nFlits) begin
          checkOutput($sformatf("vec%0d out_en beat%0d", v, k), {31'd0, bus.out_en}, 32'd1);
          if (k == 0)
            checkOutput($sformatf("vec%0d first clNum", v), {30'd0, bus.out_clNum},
                        {30'd0, vecs[v].firstCl});
          if (k == vecs[v].nFlits - 1)
            checkOutput($sformatf("vec%0d last eop", v), {31'd0, bus.out_eop},
                        {31'd0, vecs[v].lastEop});
        end else begin
          checkOutput($sformatf("vec%0d idle after packet", v), {31'd0, bus.out_en}, 32'd0);
        end
      end
    end

    // Back-to-back packed responses must issue with no bubble between them.
    applyStimulus(1'b1, 16'h0021, 1'b1, 2'd1);
    applyStimulus(1'b1, 16'h0022, 1'b1, 2'd2);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) applyStimulus(1'b0, '0, 1'b0, '0);
      @(negedge clk);
      if (k < 5) begin
        checkOutput($sformatf("b2b out_en %0d", k), {31'd0, bus.out_en}, 32'd1);
        checkOutput($sformatf("b2b clNum %0d", k), {30'd0, bus.out_clNum}, {30'd0, b2bCl[k]});
        checkOutput($sformatf("b2b eop %0d", k), {31'd0, bus.out_eop}, {31'd0, b2bEop[k]});
      end else begin
        checkOutput("b2b idle", {31'd0, bus.out_en}, 32'd0);
      end
    end
    waitDrain("b2b");

    // Sixteen 4-line responses back to back: occupancy reaches 12 after cycle 14.
    firstHigh = -1;
    for (int i = 0; i <= 16; i++) begin
      applyStimulus(i < 16, 16'h0100 + 16'(i), 1'b1, 2'd3);
      @(negedge clk);
      if (almFull && firstHigh < 0) firstHigh = i;
    end
    applyStimulus(1'b0, '0, 1'b0, '0);
    checkOutput("fill almFull first cycle", firstHigh, 32'd15);
    checkOutput("fill overflow", {31'd0, overflow}, 32'd0);
    waitDrain("fill");
    checkOutput("fill flit count", flitCount, expFlits);
    checkOutput("drained almFull", {31'd0, almFull}, 32'd0);

    // 24 responses outpace the drain; two arrive while full with no retirement.
    allowDrop    = 1'b1;
    droppedFlits = 0;
    for (int i = 0; i < 24; i++)
      applyStimulus(1'b1, 16'h0200 + 16'(i), 1'b1, 2'd3);
    applyStimulus(1'b0, '0, 1'b0, '0);
    @(negedge clk);
    checkOutput("burst almFull", {31'd0, almFull}, 32'd1);
    waitDrain("burst");
    allowDrop = 1'b0;
    checkOutput("burst overflow sticky", {31'd0, overflow}, 32'd1);
    checkOutput("burst dropped flits", droppedFlits, 32'd8);

    // Reset lands while the third flit of a 4-line response is on the output.
    applyStimulus(1'b1, 16'h0300, 1'b1, 2'd3);
    applyStimulus(1'b1, 16'h0301, 1'b1, 2'd3);
    applyStimulus(1'b1, 16'h0302, 1'b1, 2'd3);
    @(posedge clk);
    #1;
    reset         = 1'b1;
    bus.rsp_mdata = 16'h0303;
    @(negedge clk);
    checkOutput("pre-reset third flit en", {31'd0, bus.out_en}, 32'd1);
    checkOutput("pre-reset third flit clNum", {30'd0, bus.out_clNum}, 32'd2);
    @(posedge clk);
    #1;
    reset      = 1'b0;
    bus.rsp_en = 1'b0;
    sbQ.delete();
    @(negedge clk);
    checkOutput("post-reset out_en", {31'd0, bus.out_en}, 32'd0);
    checkOutput("post-reset almFull", {31'd0, almFull}, 32'd0);
    checkOutput("post-reset overflow", {31'd0, overflow}, 32'd0);
    applyStimulus(1'b0, '0, 1'b0, '0);
    @(negedge clk);
    checkOutput("post-reset quiet", {31'd0, bus.out_en}, 32'd0);
    applyStimulus(1'b1, 16'h0310, 1'b1, 2'd0);
    applyStimulus(1'b0, '0, 1'b0, '0);
    @(negedge clk);
    checkOutput("post-reset single en", {31'd0, bus.out_en}, 32'd1);
    checkOutput("post-reset single eop", {31'd0, bus.out_eop}, 32'd1);
    applyStimulus(1'b0, '0, 1'b0, '0);
    @(negedge clk);
    checkOutput("post-reset single done", {31'd0, bus.out_en}, 32'd0);
    waitDrain("reset");

    // Forty mixed responses wrap the 16-entry pointers more than twice.
    flitCount = 0;
    expFlits  = 0;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b1, 16'h0400 + 16'(i), (i % 2) == 0, 2'($urandom_range(0, 3)));
      applyStimulus(1'b0, '0, 1'b0, '0);
    end
    waitDrain("wrap");
    checkOutput("wrap flit count", flitCount, expFlits);
    checkOutput("wrap overflow", {31'd0, overflow}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cci_mpf_shim_expand_wr_rsp.md
Name: cci_mpf_shim_expand_wr_rsp

Overview:
Inverse of write-response merging. Takes packed CCI write responses (format=1, cl_num=N-1) and expands each into N single-line responses, cl_num 0..N-1, one per cycle, in arrival order. Unpacked responses pass through unchanged. Sits on the c1Rx path toward the AFU, for consumers that require one response per line. Because CCI Rx has no backpressure, the block buffers internally and asserts almost-full, which the parent ORs into c1TxAlmFull.

Parameters:
N_ENTRIES, 16, depth of the response FIFO; power of 2, ≥4.
ALM_FULL_THRESHOLD, 4, almFull asserts when free entries ≤ this value.
MDATA_WIDTH, 16, width of the mdata field carried through.

Ports:
clk  in  1  clock.
reset  in  1  synchronous, active-high.
rsp_en  in  1  write response valid this cycle.
rsp_mdata  in  MDATA_WIDTH  response mdata.
rsp_format  in  1  1 = packed response covering cl_num+1 lines.
rsp_clNum  in  2  t_cci_clNum: last line index if packed, otherwise the line index.
out_en  out  1  expanded flit valid.
out_mdata  out  MDATA_WIDTH  mdata copied from the source response.
out_clNum  out  2  line index of this flit.
out_eop  out  1  final flit of an expanded packed response.
almFull  out  1  FIFO free entries ≤ ALM_FULL_THRESHOLD.
overflow  out  1  sticky error: a response arrived while the FIFO was full.

Behaviour:
- Reset (synchronous, active-high):
  - FIFO empty; beat counter = 0.
  - out_en = 0, out_eop = 0, out_clNum = 0, out_mdata = 0.
  - almFull = 0; overflow = 0.
  - A reset asserted mid-expansion discards all stored and partially expanded packets. No output is produced in the cycle after reset deasserts unless rsp_en was sampled that cycle.
- FIFO:
  - Each entry holds {mdata, format, clNum}.
  - Enqueue on rsp_en when not full.
  - rsp_en while full: the response is dropped and overflow is set and held until reset.
  - Simultaneous enqueue and dequeue is legal when full or empty.
  - Pointers are log2(N_ENTRIES) bits plus a wrap bit; wrap-around is seamless.
- Head is the oldest entry; beat is a 2-bit counter.
- Expansion state machine:
  - IDLE:
    - FIFO empty → nothing issued.
    - Otherwise head is presented.
    - Unpacked head (format=0): emit a single flit with out_clNum = head.clNum and out_eop = 0, then dequeue.
    - Packed head with clNum=0: emit a single flit with out_clNum = 0 and out_eop = 1, then dequeue.
    - Packed head with clNum>0: emit beat 0 (out_eop = 0), set beat=1, go to EXPAND.
  - EXPAND:
    - Emit out_clNum = beat; out_eop = (beat == head.clNum).
    - On eop: dequeue, beat=0. Go to IDLE, or stay issuing if the next entry is valid. Back-to-back packets produce no bubble.
    - Otherwise beat++.
- Outputs are registered. With an empty FIFO, rsp_en at cycle t gives first out_en at t+1 (bypass through the FIFO write). A packed N-line response occupies N consecutive output cycles.
- Throughput: one output flit per cycle. Order is strictly FIFO; flits of different packets never interleave.
- almFull is registered and computed from the post-update occupancy. The threshold absorbs the pipeline of requests already issued by the time the AFU observes almFull.
- Width rules: beat and clNum are 2 bits, and no beat increment occurs past clNum=3. Occupancy counter is log2(N_ENTRIES)+1 bits.

Test Plan:
- Single packed {mdata=0x12, format=1, clNum=3} on an empty FIFO at t=0 → out_en at t=1..4, out_clNum 0,1,2,3, out_eop only at t=4, mdata=0x12 on all four flits.
- Unpacked {mdata=0x5, format=0, clNum=2} → exactly one flit at t+1 with clNum=2, eop=0.
- Back-to-back packed responses at t=0 (clNum=1) and t=1 (clNum=2) → five consecutive flits: clNum 0,1(eop) then 0,1,2(eop), with no gap.
- N_ENTRIES=16, 16 packed clNum=3 responses on consecutive cycles:
  - almFull rises once free entries ≤ 4.
  - No overflow.
  - All 64 flits emitted in order.
  - Then a burst exceeding capacity → overflow=1 sticky; the dropped entry never appears on the output.
- Reset asserted at the third flit of a 4-line expansion with 3 entries queued → next cycle out_en=0, almFull=0, overflow=0; a new packed clNum=0 response then gives one flit with eop=1.
- Pointer wrap: 40 alternating packed/unpacked responses through N_ENTRIES=16 → output sequence matches the reference-model expansion exactly.
